// File: rtl/cond_logic_ctx.sv
`default_nettype none
// ============================================================================
//  Module   : cond_logic_ctx
//  Brief    : Execute-stage condition unit with NCTX NZCV flag contexts and
//             gated branch/register/memory write controls.
//  Revision : 1.0  initial release
// ============================================================================
module cond_logic_ctx #(
    parameter int         NCTX        = 1,
    parameter int         OUT_REG     = 1,
    parameter logic [3:0] RESET_FLAGS = 4'b0000,
    localparam int        CW          = (NCTX > 1) ? $clog2(NCTX) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          StallE,
    input  logic          FlushE,
    input  logic [CW-1:0] CtxSel,
    input  logic [3:0]    Cond,
    input  logic [3:0]    ALUFlags,
    input  logic [1:0]    FlagW,
    input  logic          PCS,
    input  logic          RegW,
    input  logic          MemW,
    input  logic          NoWrite,
    output logic          CondEx,
    output logic          PCSrc,
    output logic          RegWrite,
    output logic          MemWrite,
    output logic          Undef,
    output logic [3:0]    Flags
);

    logic [3:0]      r_flags [NCTX];
    logic [NCTX-1:0] w_ctx_oh;
    logic [3:0]      w_f;
    logic            w_n, w_z, w_c, w_v;
    logic            w_pass;
    logic            w_undef_raw;
    logic            w_live;
    logic            w_flag_we;
    logic            w_condex;
    logic            w_pcsrc;
    logic            w_regwrite;
    logic            w_memwrite;
    logic            w_undef;

    // Out-of-range selects fall back to context 0.
    always_comb begin
        w_ctx_oh = '0;
        w_f      = r_flags[0];
        for (int i = 0; i < NCTX; i++) begin
            if (CtxSel == CW'(i)) begin
                w_ctx_oh[i] = 1'b1;
                w_f         = r_flags[i];
            end
        end
        if (w_ctx_oh == '0) begin
            w_ctx_oh[0] = 1'b1;
        end
    end

    assign {w_n, w_z, w_c, w_v} = w_f;
    assign Flags = w_f;

    always_comb begin
        w_pass      = 1'b0;
        w_undef_raw = 1'b0;
        case (Cond)
            4'b0000: w_pass = w_z;
            4'b0001: w_pass = !w_z;
            4'b0010: w_pass = w_c;
            4'b0011: w_pass = !w_c;
            4'b0100: w_pass = w_n;
            4'b0101: w_pass = !w_n;
            4'b0110: w_pass = w_v;
            4'b0111: w_pass = !w_v;
            4'b1000: w_pass = w_c & !w_z;
            4'b1001: w_pass = !(w_c & !w_z);
            4'b1010: w_pass = (w_n == w_v);
            4'b1011: w_pass = (w_n != w_v);
            4'b1100: w_pass = !w_z & (w_n == w_v);
            4'b1101: w_pass = !(!w_z & (w_n == w_v));
            4'b1110: w_pass = 1'b1;
            default: begin
                w_pass      = 1'b0;
                w_undef_raw = 1'b1;
            end
        endcase
    end

    assign w_live     = w_pass & !FlushE;
    assign w_condex   = w_live;
    assign w_pcsrc    = PCS & w_live;
    assign w_regwrite = RegW & !NoWrite & w_live;
    assign w_memwrite = MemW & w_live;
    assign w_undef    = w_undef_raw & !FlushE;

    // Condition uses pre-update flags; the write lands for the next instruction.
    assign w_flag_we = !StallE & !FlushE & w_pass;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCTX; i++) begin
                r_flags[i] <= RESET_FLAGS;
            end
        end else if (w_flag_we) begin
            for (int i = 0; i < NCTX; i++) begin
                if (w_ctx_oh[i]) begin
                    if (FlagW[1]) r_flags[i][3:2] <= ALUFlags[3:2];
                    if (FlagW[0]) r_flags[i][1:0] <= ALUFlags[1:0];
                end
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic r_condex, r_pcsrc, r_regwrite, r_memwrite, r_undef;

            // Flush clears the stage even while stalled.
            always_ff @(posedge clk) begin
                if (reset || FlushE) begin
                    r_condex   <= 1'b0;
                    r_pcsrc    <= 1'b0;
                    r_regwrite <= 1'b0;
                    r_memwrite <= 1'b0;
                    r_undef    <= 1'b0;
                end else if (!StallE) begin
                    r_condex   <= w_condex;
                    r_pcsrc    <= w_pcsrc;
                    r_regwrite <= w_regwrite;
                    r_memwrite <= w_memwrite;
                    r_undef    <= w_undef;
                end
            end

            assign CondEx   = r_condex;
            assign PCSrc    = r_pcsrc;
            assign RegWrite = r_regwrite;
            assign MemWrite = r_memwrite;
            assign Undef    = r_undef;
        end else begin : g_out_comb
            assign CondEx   = w_condex;
            assign PCSrc    = w_pcsrc;
            assign RegWrite = w_regwrite;
            assign MemWrite = w_memwrite;
            assign Undef    = w_undef;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cond_logic_ctx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cond_logic_ctx
//  Brief    : Directed bench for cond_logic_ctx in comb, registered and
//             multi-context configurations sharing one stimulus stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cond_logic_ctx;

    logic       clk = 1'b0;
    logic       reset, stalle, flushe;
    logic [1:0] ctxsel;
    logic [3:0] cond, aluflags;
    logic [1:0] flagw;
    logic       pcs, regw, memw, nowrite;

    logic       a_condex, a_pcsrc, a_regwrite, a_memwrite, a_undef;
    logic [3:0] a_flags;
    logic       b_condex, b_pcsrc, b_regwrite, b_memwrite, b_undef;
    logic [3:0] b_flags;
    logic       c_condex, c_pcsrc, c_regwrite, c_memwrite, c_undef;
    logic [3:0] c_flags;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // a: single context, combinational outputs
    cond_logic_ctx #(.NCTX(1), .OUT_REG(0), .RESET_FLAGS(4'b0000)) u_comb (
        .clk(clk), .reset(reset), .StallE(stalle), .FlushE(flushe),
        .CtxSel(ctxsel[0:0]), .Cond(cond), .ALUFlags(aluflags), .FlagW(flagw),
        .PCS(pcs), .RegW(regw), .MemW(memw), .NoWrite(nowrite),
        .CondEx(a_condex), .PCSrc(a_pcsrc), .RegWrite(a_regwrite),
        .MemWrite(a_memwrite), .Undef(a_undef), .Flags(a_flags)
    );

    // b: single context, registered outputs
    cond_logic_ctx #(.NCTX(1), .OUT_REG(1), .RESET_FLAGS(4'b0000)) u_reg (
        .clk(clk), .reset(reset), .StallE(stalle), .FlushE(flushe),
        .CtxSel(ctxsel[0:0]), .Cond(cond), .ALUFlags(aluflags), .FlagW(flagw),
        .PCS(pcs), .RegW(regw), .MemW(memw), .NoWrite(nowrite),
        .CondEx(b_condex), .PCSrc(b_pcsrc), .RegWrite(b_regwrite),
        .MemWrite(b_memwrite), .Undef(b_undef), .Flags(b_flags)
    );

    // c: four contexts, registered outputs
    cond_logic_ctx #(.NCTX(4), .OUT_REG(1), .RESET_FLAGS(4'b0000)) u_ctx (
        .clk(clk), .reset(reset), .StallE(stalle), .FlushE(flushe),
        .CtxSel(ctxsel), .Cond(cond), .ALUFlags(aluflags), .FlagW(flagw),
        .PCS(pcs), .RegW(regw), .MemW(memw), .NoWrite(nowrite),
        .CondEx(c_condex), .PCSrc(c_pcsrc), .RegWrite(c_regwrite),
        .MemWrite(c_memwrite), .Undef(c_undef), .Flags(c_flags)
    );

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b exp=%b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference condition table, written directly from the instruction set.
    function automatic logic cond_exp(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle_inputs;
        stalle = 0; flushe = 0; ctxsel = 0; cond = 4'hE; aluflags = 0;
        flagw = 0; pcs = 0; regw = 0; memw = 0; nowrite = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    initial begin
        logic e;
        reset = 1;
        idle_inputs();

        // Reset state
        step();
        chk("rst_b_condex", {3'b0, b_condex}, 4'h0);
        chk("rst_b_pcsrc",  {3'b0, b_pcsrc},  4'h0);
        chk("rst_b_regw",   {3'b0, b_regwrite}, 4'h0);
        chk("rst_b_memw",   {3'b0, b_memwrite}, 4'h0);
        chk("rst_b_undef",  {3'b0, b_undef},  4'h0);
        chk("rst_a_flags",  a_flags, 4'h0);
        chk("rst_c_flags",  c_flags, 4'h0);
        reset = 0;

        // Sweep all Cond codes over every flag value
        for (int f = 0; f < 16; f++) begin
            cond = 4'hE; flagw = 2'b11; aluflags = 4'(f);
            pcs = 0; regw = 0; memw = 0;
            step();
            flagw = 2'b00; pcs = 1; regw = 1; memw = 1;
            for (int c = 0; c < 16; c++) begin
                cond = 4'(c);
                nowrite = c[0];
                #1;
                e = cond_exp(4'(c), 4'(f));
                chk("sweep_condex", {3'b0, a_condex}, {3'b0, e});
                chk("sweep_undef",  {3'b0, a_undef},  {3'b0, (c == 15)});
                chk("sweep_pcsrc",  {3'b0, a_pcsrc},  {3'b0, e});
                chk("sweep_regw",   {3'b0, a_regwrite}, {3'b0, e & !c[0]});
                chk("sweep_memw",   {3'b0, a_memwrite}, {3'b0, e});
                step();
            end
            chk("sweep_flags_hold", a_flags, 4'(f));
        end

        // Write-then-use, comb and registered
        do_reset();
        cond = 4'hE; flagw = 2'b11; aluflags = 4'b0100; pcs = 0;
        #1;
        chk("wtu_old_flags", a_flags, 4'h0);
        chk("wtu_c1_condex", {3'b0, a_condex}, 4'h1);
        step();
        cond = 4'h0; flagw = 2'b00; pcs = 1;
        #1;
        chk("wtu_new_flags", a_flags, 4'b0100);
        chk("wtu_a_pcsrc",   {3'b0, a_pcsrc}, 4'h1);
        chk("wtu_b_pcsrc_c2", {3'b0, b_pcsrc}, 4'h0);
        chk("wtu_b_condex_c2", {3'b0, b_condex}, 4'h1);
        step();
        pcs = 0; cond = 4'hE;
        #1;
        chk("wtu_b_pcsrc_c3", {3'b0, b_pcsrc}, 4'h1);

        // Partial flag writes and failed-condition write suppression
        cond = 4'hE; flagw = 2'b11; aluflags = 4'hF;
        step();
        flagw = 2'b10; aluflags = 4'h0;
        step();
        chk("part_nz", a_flags, 4'b0011);
        flagw = 2'b01; aluflags = 4'h0;
        step();
        chk("part_cv", a_flags, 4'b0000);
        cond = 4'h0; flagw = 2'b11; aluflags = 4'hF; regw = 1;
        #1;
        chk("fail_regw",   {3'b0, a_regwrite}, 4'h0);
        chk("fail_condex", {3'b0, a_condex}, 4'h0);
        step();
        chk("fail_noflag", a_flags, 4'h0);
        regw = 0; flagw = 0;

        // Multiple contexts
        do_reset();
        ctxsel = 2'd2; cond = 4'hE; flagw = 2'b11; aluflags = 4'b1000;
        step();
        flagw = 0;
        for (int s = 0; s < 4; s++) begin
            ctxsel = 2'(s);
            #1;
            chk("ctx_flags", c_flags, (s == 2) ? 4'b1000 : 4'b0000);
        end
        ctxsel = 2'd1;
        #1;
        chk("ctx_oor_to_0", a_flags, 4'b1000);
        ctxsel = 2'd2; cond = 4'h4;
        step();
        chk("ctx2_mi", {3'b0, c_condex}, 4'h1);
        ctxsel = 2'd0;
        step();
        chk("ctx0_mi", {3'b0, c_condex}, 4'h0);

        // Stall and flush on registered outputs
        do_reset();
        cond = 4'hE; regw = 1; flagw = 0;
        step();
        chk("sf_regw_on",   {3'b0, b_regwrite}, 4'h1);
        chk("sf_condex_on", {3'b0, b_condex}, 4'h1);
        stalle = 1; regw = 0; flagw = 2'b11; aluflags = 4'hF;
        #1;
        chk("stall_comb_regw", {3'b0, a_regwrite}, 4'h0);
        step();
        chk("stall_hold_regw", {3'b0, b_regwrite}, 4'h1);
        chk("stall_b_flags", b_flags, 4'h0);
        chk("stall_a_flags", a_flags, 4'h0);
        stalle = 0; flushe = 1; regw = 1;
        #1;
        chk("flush_comb_regw", {3'b0, a_regwrite}, 4'h0);
        step();
        chk("flush_b_regw",   {3'b0, b_regwrite}, 4'h0);
        chk("flush_b_condex", {3'b0, b_condex}, 4'h0);
        chk("flush_b_flags",  b_flags, 4'h0);
        flushe = 0; flagw = 0;
        step();
        chk("sf_regw_again", {3'b0, b_regwrite}, 4'h1);
        flushe = 1; stalle = 1;
        step();
        chk("fs_regw",   {3'b0, b_regwrite}, 4'h0);
        chk("fs_condex", {3'b0, b_condex}, 4'h0);
        flushe = 0; stalle = 0; regw = 0;
        cond = 4'hF;
        #1;
        chk("undef_comb",   {3'b0, a_undef}, 4'h1);
        chk("undef_condex", {3'b0, a_condex}, 4'h0);
        step();
        chk("undef_reg", {3'b0, b_undef}, 4'h1);
        flushe = 1;
        #1;
        chk("undef_flush_comb", {3'b0, a_undef}, 4'h0);
        step();
        chk("undef_flush_reg", {3'b0, b_undef}, 4'h0);
        flushe = 0;

        // Reset in the middle of a flag-writing instruction
        cond = 4'hE; pcs = 1; regw = 1; memw = 1;
        step();
        chk("pre_rst_memw", {3'b0, b_memwrite}, 4'h1);
        reset = 1; flagw = 2'b11; aluflags = 4'hF;
        step();
        chk("mrst_condex", {3'b0, b_condex}, 4'h0);
        chk("mrst_pcsrc",  {3'b0, b_pcsrc}, 4'h0);
        chk("mrst_regw",   {3'b0, b_regwrite}, 4'h0);
        chk("mrst_memw",   {3'b0, b_memwrite}, 4'h0);
        chk("mrst_undef",  {3'b0, b_undef}, 4'h0);
        chk("mrst_a_flags", a_flags, 4'h0);
        chk("mrst_b_flags", b_flags, 4'h0);
        reset = 0; flagw = 0; pcs = 0; regw = 0; memw = 0; cond = 4'h1;
        #1;
        chk("post_rst_ne_comb", {3'b0, a_condex}, 4'h1);
        step();
        chk("post_rst_ne_reg", {3'b0, b_condex}, 4'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
